// File: rtl/oversample_multi.sv
// rtl/oversample_multi.sv - multi-channel 4^L oversampler with FWFT output FIFO
module oversample_multi #(
  parameter int NUM_CH       = 4,
  parameter int IN_W         = 12,
  parameter int MAX_LOG4_OSR = 4,
  parameter int FIFO_DEPTH   = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OUT_W = IN_W + MAX_LOG4_OSR,
  localparam int L_W   = $clog2(MAX_LOG4_OSR + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              eoc,
  input  logic [CH_W-1:0]   channel,
  input  logic [IN_W-1:0]   sample,
  input  logic [L_W-1:0]    log4_osr,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_channel,
  output logic              overflow
);

  localparam int SUM_W = IN_W + 2 * MAX_LOG4_OSR;
  localparam int CNT_W = 2 * MAX_LOG4_OSR;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = CH_W + OUT_W;

  // Per-channel accumulation state
  logic [SUM_W-1:0] acc   [NUM_CH];
  logic [CNT_W-1:0] cnt   [NUM_CH];
  logic [L_W-1:0]   lat_l [NUM_CH];

  // Datapath for the channel addressed this cycle
  logic             accept;
  logic [L_W-1:0]   l_req;
  logic [SUM_W-1:0] cur_acc;
  logic [CNT_W-1:0] cur_cnt;
  logic [L_W-1:0]   cur_lat;
  logic [L_W-1:0]   eff_l;
  logic [SUM_W-1:0] total;
  logic [SUM_W-1:0] res_wide;
  logic [OUT_W-1:0] result;
  logic             last;
  logic             push_req;

  // FIFO state
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic [ENT_W-1:0] head;

  // Accept decode, L selection (new block latches, running block keeps its L) and block result
  always_comb begin
    accept   = 1'b0;
    l_req    = log4_osr;
    cur_acc  = '0;
    cur_cnt  = '0;
    cur_lat  = '0;
    eff_l    = '0;
    total    = '0;
    res_wide = '0;
    result   = '0;
    last     = 1'b0;
    push_req = 1'b0;
    if (32'(log4_osr) > MAX_LOG4_OSR) l_req = L_W'(MAX_LOG4_OSR);
    if (32'(channel) < NUM_CH) begin
      accept  = eoc & ch_enable[channel];
      cur_acc = acc[channel];
      cur_cnt = cnt[channel];
      cur_lat = lat_l[channel];
    end
    eff_l    = (cur_cnt == '0) ? l_req : cur_lat;
    total    = cur_acc + SUM_W'(sample);
    last     = (32'(cur_cnt) == ((32'd1 << (32'd2 * 32'(eff_l))) - 32'd1));
    res_wide = (total >> eff_l) << (L_W'(MAX_LOG4_OSR) - eff_l);
    result   = res_wide[OUT_W-1:0];
    push_req = accept & last & ~reset;
  end

  // Per-channel read-modify-write; a disabled channel discards its partial block
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        acc[c]   <= '0;
        cnt[c]   <= '0;
        lat_l[c] <= '0;
      end else if (!ch_enable[c]) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end else if (accept && (32'(channel) == c)) begin
        if (cur_cnt == '0) lat_l[c] <= l_req;
        if (last) begin
          acc[c] <= '0;
          cnt[c] <= '0;
        end else begin
          acc[c] <= total;
          cnt[c] <= cur_cnt + CNT_W'(1);
        end
      end
    end
  end

  // FIFO flags; a push into a full FIFO is allowed when the head leaves in the same cycle
  always_comb begin
    full        = (count == (AW+1)'(FIFO_DEPTH));
    out_valid   = (count != '0);
    pop         = out_valid & out_ready;
    push_ok     = push_req & (~full | pop);
    head        = mem[rd_ptr];
    out_data    = out_valid ? head[OUT_W-1:0] : '0;
    out_channel = out_valid ? head[ENT_W-1:OUT_W] : '0;
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {channel, result};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  // Sticky drop flag
  always_ff @(posedge clk) begin
    if (reset)                    overflow <= 1'b0;
    else if (push_req & ~push_ok) overflow <= 1'b1;
  end

endmodule
